multicycle_ctrl: RTL

//  Multi-cycle MIPS control FSM. It sequences the shared datapath: PC, IR, regfile, ALU, extender and data memory.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mc_ctrl_decode.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg : opcode/funct values, state encoding and control-field codes
//                 shared by the multi-cycle MIPS controller.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MDR = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;

    localparam logic [1:0] ALUB_RT    = 2'd0;
    localparam logic [1:0] ALUB_FOUR  = 2'd1;
    localparam logic [1:0] ALUB_IMM   = 2'd2;
    localparam logic [1:0] ALUB_IMMSH = 2'd3;

    localparam logic EXT_ZERO = 1'b1;
    localparam logic EXT_SIGN = 1'b0;

    // ALU operation for the supported R-type arithmetic (addu/subu).
    function automatic logic [2:0] alu_r_op(input logic [5:0] funct);
        return (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// ============================================================================
// mc_ctrl_decode : combinational op/funct -> one-hot instruction class.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic       is_alu_r_o,
    output logic       is_ori_o,
    output logic       is_lui_o,
    output logic       is_lw_o,
    output logic       is_sw_o,
    output logic       is_beq_o,
    output logic       is_jal_o,
    output logic       is_jr_o,
    output logic       is_nop_o
);

    logic w_rtype;

    assign w_rtype    = (op_i == OP_RTYPE);
    assign is_alu_r_o = w_rtype && ((funct_i == FN_ADDU) || (funct_i == FN_SUBU));
    assign is_jr_o    = w_rtype && (funct_i == FN_JR);
    assign is_ori_o   = (op_i == OP_ORI);
    assign is_lui_o   = (op_i == OP_LUI);
    assign is_lw_o    = (op_i == OP_LW);
    assign is_sw_o    = (op_i == OP_SW);
    assign is_beq_o   = (op_i == OP_BEQ);
    assign is_jal_o   = (op_i == OP_JAL);

    // Anything unrecognised (bad opcode or R-type with unknown funct) runs as a nop.
    assign is_nop_o   = !(is_alu_r_o || is_jr_o || is_ori_o || is_lui_o ||
                          is_lw_o || is_sw_o || is_beq_o || is_jal_o);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB)
//                   driving the shared datapath's enables and selects.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       MemWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtOp,
    output logic       instr_done,
    output logic [2:0] state
);

    state_t state_q;
    state_t state_d;

    logic is_alu_r, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_jr, is_nop;
    logic mem_go;

    mc_ctrl_decode u_decode (
        .op_i       (op),
        .funct_i    (funct),
        .is_alu_r_o (is_alu_r),
        .is_ori_o   (is_ori),
        .is_lui_o   (is_lui),
        .is_lw_o    (is_lw),
        .is_sw_o    (is_sw),
        .is_beq_o   (is_beq),
        .is_jal_o   (is_jal),
        .is_jr_o    (is_jr),
        .is_nop_o   (is_nop)
    );

    assign mem_go = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state  = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by reset so an in-flight instruction can't write anything.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        PCSrc      = PCSRC_ALU;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = REGDST_RT;
        MemtoReg   = MEMTOREG_ALU;
        MemWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = ALUB_RT;
        ALUOp      = ALU_ADD;
        ExtOp      = EXT_SIGN;
        instr_done = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_ALU;
                    ALUSrcA = 1'b0;
                    ALUSrcB = ALUB_FOUR;
                    ALUOp   = ALU_ADD;
                    state_d = S_DECODE;
                end

                S_DECODE: begin
                    ALUSrcA = 1'b0;
                    ALUSrcB = ALUB_IMMSH;
                    ExtOp   = EXT_SIGN;
                    ALUOp   = ALU_ADD;
                    if (is_jal) begin
                        RegWrite   = 1'b1;
                        RegDst     = REGDST_RA;
                        MemtoReg   = MEMTOREG_PC;
                        PCWrite    = 1'b1;
                        PCSrc      = PCSRC_JUMP;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else if (is_nop) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end

                S_EXEC: begin
                    state_d = S_FETCH;
                    if (is_alu_r) begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = ALUB_RT;
                        ALUOp   = alu_r_op(funct);
                        state_d = S_WB;
                    end else if (is_jr) begin
                        PCWrite    = 1'b1;
                        PCSrc      = PCSRC_RS;
                        instr_done = 1'b1;
                    end else if (is_ori) begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = ALUB_IMM;
                        ExtOp   = EXT_ZERO;
                        ALUOp   = ALU_OR;
                        state_d = S_WB;
                    end else if (is_lui) begin
                        ALUSrcB = ALUB_IMM;
                        ExtOp   = EXT_ZERO;
                        ALUOp   = ALU_LUI;
                        state_d = S_WB;
                    end else if (is_lw || is_sw) begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = ALUB_IMM;
                        ExtOp   = EXT_SIGN;
                        ALUOp   = ALU_ADD;
                        state_d = S_MEM;
                    end else if (is_beq) begin
                        ALUSrcA    = 1'b1;
                        ALUSrcB    = ALUB_RT;
                        ALUOp      = ALU_SUB;
                        PCSrc      = PCSRC_ALUOUT;
                        PCWrite    = zero;
                        instr_done = 1'b1;
                    end else begin
                        instr_done = 1'b1;
                    end
                end

                S_MEM: begin
                    if (is_sw) begin
                        MemWrite = 1'b1;
                        if (mem_go) begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end else if (is_lw) begin
                        if (mem_go) begin
                            state_d = S_WB;
                        end
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end

                S_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                    if (is_alu_r) begin
                        RegDst = REGDST_RD;
                    end else if (is_lw) begin
                        MemtoReg = MEMTOREG_MDR;
                    end
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
